// File: rtl/ppong_rd_ctrl.sv
// ppong_rd_ctrl
//
// Read-side controller for the rearranging ping-pong buffer. A bank is written
// row-major as ROWS x COLS words. This block reads it back column-major from
// the RAM read port, which has a combinational read. It presents the samples
// as an AXI4-Stream master. Once a bank is fully consumed it is handed back to
// the writer.
//
// Build option:
//   RD_TLAST_PER_COL_EN  When defined, tlast marks the last sample of every
//                        column, giving COLS packets per bank. When undefined,
//                        tlast marks only the final sample of the bank.
//                        bank_rel fires on the bank's final beat in both cases.
//
// Ports:
//   clk            single clock
//   resetn         asynchronous active-low reset
//   bank_rdy[1:0]  one-cycle pulse from the writer: bank b is full
//   bank_rel[1:0]  one-cycle pulse to the writer: bank b is read and free
//   ovf_err        sticky; a bank_rdy hit a bank that was pending or owned
//   ram_enb        RAM read enable
//   ram_addrb      RAM read address {bank, row*COLS+col}
//   ram_dob        RAM read data, valid in the same cycle as ram_addrb
//   m_axis_*       AXI4-Stream master (tdata/tvalid/tready/tlast)

module ppong_rd_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned ADDRW      = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            bank_rdy,
  output logic [1:0]            bank_rel,
  output logic                  ovf_err,
  output logic                  ram_enb,
  output logic [ADDRW:0]        ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

  // State
  state_e                state_q, state_d;
  logic [1:0]            pending_q, pending_d;
  logic                  next_bank_q, next_bank_d;
  logic                  cur_bank_q, cur_bank_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [1:0]            rel_q, rel_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;

  // Decode
  logic [1:0]       busy;       // bank owned by the reader, including its release cycle
  logic [1:0]       rdy_ok;     // bank_rdy pulses that are accepted
  logic [1:0]       rdy_ovf;    // bank_rdy pulses that overflow
  logic [1:0]       avail;      // bank ready to start, including a same-cycle pulse
  logic             load;       // output register can take a new sample
  logic             row_end;    // current element is the last one of its column
  logic             last_elem;  // current element is the last one of the bank
  logic             tlast_set;
  logic [ADDRW-1:0] word_addr;

  always_comb begin
    busy = rel_q;
    if (state_q != StIdle) begin
      busy[cur_bank_q] = 1'b1;
    end
  end

  assign rdy_ovf   = bank_rdy & (pending_q | busy);
  assign rdy_ok    = bank_rdy & ~(pending_q | busy);
  // A pulse for next_bank seen in IDLE starts the read at once, which saves a cycle.
  assign avail     = pending_q | rdy_ok;
  assign load      = !tvalid_q || m_axis_tready;
  assign row_end   = (row_q == RowLast);
  assign last_elem = row_end && (col_q == ColLast);
  assign word_addr = ADDRW'(32'(row_q) * COLS + 32'(col_q));

`ifdef RD_TLAST_PER_COL_EN
  assign tlast_set = row_end;
`else
  assign tlast_set = last_elem;
`endif

  // Next state and outputs
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | rdy_ok;
    next_bank_d = next_bank_q;
    cur_bank_d  = cur_bank_q;
    row_d       = row_q;
    col_d       = col_q;
    rel_d       = 2'b00;
    ovf_d       = ovf_q | (|rdy_ovf);
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    ram_enb     = 1'b0;
    ram_addrb   = '0;

    case (state_q)
      StIdle: begin
        if (avail[next_bank_q]) begin
          state_d                = StRead;
          cur_bank_d             = next_bank_q;
          pending_d[next_bank_q] = 1'b0;
          row_d                  = '0;
          col_d                  = '0;
        end
      end

      StRead: begin
        ram_enb   = load;
        ram_addrb = {cur_bank_q, word_addr};
        if (load) begin
          tdata_d  = ram_dob;
          tvalid_d = 1'b1;
          tlast_d  = tlast_set;
          // Row is the fast index, so the bank comes out column-major.
          if (last_elem) begin
            state_d = StDrain;
            row_d   = '0;
            col_d   = '0;
          end else if (row_end) begin
            row_d = '0;
            col_d = col_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      StDrain: begin
        // The final beat is still in the output register. The bank is freed
        // only after that beat is accepted.
        if (tvalid_q && m_axis_tready && tlast_q) begin
          rel_d[cur_bank_q] = 1'b1;
          next_bank_d       = ~next_bank_q;
          state_d           = StIdle;
          tvalid_d          = 1'b0;
          tlast_d           = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      pending_q   <= 2'b00;
      next_bank_q <= 1'b0;
      cur_bank_q  <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      rel_q       <= 2'b00;
      ovf_q       <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      next_bank_q <= next_bank_d;
      cur_bank_q  <= cur_bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rel_q       <= rel_d;
      ovf_q       <= ovf_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign bank_rel      = rel_q;
  assign ovf_err       = ovf_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_ppong_rd_ctrl.sv
// Self-checking bench for ppong_rd_ctrl (ROWS=4, COLS=4). The RAM model holds
// word a = a in bank 0 and a+100 in bank 1. The reference model tracks each
// bank's ownership and the alternating service order. It derives every
// expected beat from the transpose rule.

module tb_ppong_rd_ctrl;

  localparam int DW = 32;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int AW = 4;
  localparam int N  = R * C;

  logic          clk;
  logic          resetn;
  logic [1:0]    bank_rdy;
  logic [1:0]    bank_rel;
  logic          ovf_err;
  logic          ram_enb;
  logic [AW:0]   ram_addrb;
  logic [DW-1:0] ram_dob;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  ppong_rd_ctrl #(
    .DATA_WIDTH(DW),
    .ROWS      (R),
    .COLS      (C),
    .ADDRW     (AW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bank_rdy     (bank_rdy),
    .bank_rel     (bank_rel),
    .ovf_err      (ovf_err),
    .ram_enb      (ram_enb),
    .ram_addrb    (ram_addrb),
    .ram_dob      (ram_dob),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  // Combinational-read RAM
  always_comb ram_dob = 32'(ram_addrb[AW-1:0]) + (ram_addrb[AW] ? 32'd100 : 32'd0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  // Reference model
  logic [1:0]    held;       // bank full and not yet handed back (pending, read, or releasing)
  int            turn;       // bank whose beats come next
  int            k;          // beats of the current bank consumed so far
  logic [1:0]    exp_rel;
  logic          exp_ovf;
  int            banks_done;
  logic          stall_prev;
  logic [DW-1:0] prev_data;
  int            cyc;
  int            c0;
  int            b0;
  int            wi;
  logic [1:0]    rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int bank, input int idx);
    return 32'((idx % R) * C + idx / R + ((bank != 0) ? 100 : 0));
  endfunction

  function automatic logic exp_last(input int idx);
`ifdef RD_TLAST_PER_COL_EN
    return (idx % R) == (R - 1);
`else
    return idx == (N - 1);
`endif
  endfunction

  task automatic model_reset();
    held       = 2'b00;
    turn       = 0;
    k          = 0;
    exp_rel    = 2'b00;
    exp_ovf    = 1'b0;
    stall_prev = 1'b0;
    prev_data  = '0;
  endtask

  // One clock cycle: drive the inputs, check the outputs, then advance the model.
  task automatic step(input logic [1:0] rdy, input logic rdy_t);
    logic [1:0] rel_next;
    logic       ovf_next;
    @(negedge clk);
    bank_rdy      = rdy;
    m_axis_tready = rdy_t;
    #1;
    cyc++;
    chk("bank_rel", 32'(bank_rel), 32'(exp_rel));
    chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
    chk("valid_owner", 32'(m_axis_tvalid & ~held[turn]), 32'd0);
    if (stall_prev) begin
      chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
      chk("stall_data", m_axis_tdata, prev_data);
    end
    if (m_axis_tvalid && !m_axis_tready) chk("stall_no_read", 32'(ram_enb), 32'd0);
    rel_next = 2'b00;
    ovf_next = 1'b0;
    if (m_axis_tvalid && m_axis_tready) begin
      chk("beat_data", m_axis_tdata, exp_word(turn, k));
      chk("beat_last", 32'(m_axis_tlast), 32'(exp_last(k)));
      k++;
      if (k == N) begin
        rel_next[turn] = 1'b1;
        turn           = turn ^ 1;
        k              = 0;
        banks_done++;
      end
    end
    for (int b = 0; b < 2; b++) begin
      if (rdy[b]) begin
        if (held[b]) ovf_next = 1'b1;
        else held[b] = 1'b1;
      end
    end
    held       = held & ~exp_rel;
    exp_rel    = rel_next;
    exp_ovf    = exp_ovf | ovf_next;
    stall_prev = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
  endtask

  function automatic logic tr(input int mode, input int i);
    if (mode == 1) return (i % 3) == 0;
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  // Run until every bank the model holds has been released, within a bound.
  task automatic run(input int mode, input int bound);
    int i;
    i = 0;
    while ((held != 2'b00 || exp_rel != 2'b00) && i < bound) begin
      step(2'b00, tr(mode, i));
      i++;
    end
    chk("drain_done", 32'({held, exp_rel}), 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    resetn        = 1'b0;
    bank_rdy      = 2'b00;
    m_axis_tready = 1'b1;
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_bank_rel", 32'(bank_rel), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_ram_enb", 32'(ram_enb), 32'd0);
    chk("rst_ram_addrb", 32'(ram_addrb), 32'd0);
    repeat (n) @(negedge clk);
    chk("rst_hold_tvalid", 32'(m_axis_tvalid), 32'd0);
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total         = 0;
    bad           = 0;
    banks_done    = 0;
    cyc           = 0;
    resetn        = 1'b1;
    bank_rdy      = 2'b00;
    m_axis_tready = 1'b0;
    model_reset();
    #1;
    do_reset(2);

    // Single bank with tready high: latency and full throughput
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    chk("lat_not_yet", 32'(m_axis_tvalid), 32'd0);
    step(2'b00, 1'b1);
    chk("lat_first_valid", 32'(m_axis_tvalid), 32'd1);
    chk("lat_first_data", m_axis_tdata, 32'd0);
    c0 = cyc;
    run(0, 40);
    chk("throughput", 32'(cyc - c0), 32'd16);
    chk("single_banks", 32'(banks_done), 32'd1);
    repeat (3) step(2'b00, 1'b1);

    // Backpressure: tready 1,0,0 repeating (bank 1 is next)
    b0 = banks_done;
    step(2'b10, 1'b1);
    run(1, 120);
    chk("bp_banks", 32'(banks_done - b0), 32'd1);

    // Ping-pong: bank 1 first, then bank 0 three cycles later
    b0 = banks_done;
    repeat (2) step(2'b00, 1'b1);
    step(2'b10, 1'b1);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    step(2'b01, 1'b1);
    run(2, 200);
    chk("pp_banks", 32'(banks_done - b0), 32'd2);

    // Overflow: extra pulses for bank 0 while it is being read
    b0 = banks_done;
    step(2'b01, 1'b1);
    repeat (4) step(2'b00, 1'b1);
    step(2'b01, 1'b0);
    repeat (3) step(2'b00, 1'b1);
    step(2'b01, 1'b1);
    run(0, 60);
    repeat (5) step(2'b00, 1'b1);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    chk("ovf_once", 32'(banks_done - b0), 32'd1);

    // Reset after beat 6 of a bank, then restart
    do_reset(2);
    step(2'b01, 1'b1);
    wi = 0;
    while (k < 6 && wi < 40) begin
      step(2'b00, 1'b1);
      wi++;
    end
    chk("reach_beat6", 32'(k), 32'd6);
    do_reset(3);
    step(2'b00, 1'b1);
    chk("post_rst_idle", 32'(m_axis_tvalid), 32'd0);
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    chk("restart_valid", 32'(m_axis_tvalid), 32'd1);
    chk("restart_data", m_axis_tdata, 32'd0);
    run(0, 40);

    // Randomized traffic and backpressure
    for (int i = 0; i < 1500; i++) begin
      rr[0] = ($urandom_range(0, 19) == 0);
      rr[1] = ($urandom_range(0, 19) == 0);
      step(rr, $urandom_range(0, 3) != 0);
    end
    run(0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
